mcu_lsu: RTL and testbench

Load/store unit placed directly upstream of the 32-bit word-addressed data memory. It accepts one byte-addressed CPU load or store at a time, with byte, halfword or word size. Loads are returned zero- or sign-extended. Sub-word stores are done as a read-modify-write, because the memory only writes whole words. Alignment and range errors are reported to the core, and an erroring request never reaches the memory.

---
 rtl/mcu_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_mcu_lsu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_lsu.sv
// Load/store unit in front of a 32-bit word-addressed data memory; sub-word stores use read-modify-write.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses; otherwise low address bits are truncated.
module mcu_lsu #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state_reg, state_next;

  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       mem_wdata_reg;
  logic              err_reg;

  logic              handshake;
  logic [ADDR_W-1:0] req_word_idx;
  logic              size_bad;
  logic              range_bad;
  logic              align_bad;
  logic              req_err;

  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       merged_word;
  logic [31:0]       load_shift;
  logic [31:0]       load_ext;

  assign handshake    = req_valid & req_ready;
  assign req_word_idx = req_addr >> 2;
  assign size_bad     = (req_size == SZ_BAD);
  // Compare the full index so high address bits can never alias back into range.
  assign range_bad    = (req_word_idx >= ADDR_W'(MEM_WORDS));

`ifdef LSU_ALIGN_CHECK_EN
  assign align_bad = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif

  assign req_err = size_bad | range_bad | align_bad;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          if (req_err) begin
            state_next = RESP;
          end else if (!req_we) begin
            state_next = READ;
          end else if (req_size == SZ_WORD) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only, so mem_we drops with the asynchronous reset.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      WRITE:   mem_we    = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign mem_address = addr_reg >> 2;
  assign mem_wdata   = mem_wdata_reg;
  assign rsp_rdata   = rdata_reg;
  assign rsp_err     = err_reg;

  // Store data replicated across all lanes; byte_en picks which lanes are replaced.
  always_comb begin
    wdata_rep = wdata_reg;
    case (size_reg)
      SZ_BYTE: wdata_rep = {4{wdata_reg[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata_reg[15:0]}};
      default: wdata_rep = wdata_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (size_reg)
          SZ_BYTE: byte_en[gi] = (addr_reg[1:0] == 2'(gi));
          SZ_HALF: byte_en[gi] = (addr_reg[1] == 1'(gi / 2));
          default: byte_en[gi] = 1'b1;
        endcase
      end
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8]
                                                  : mem_rdata[gi*8 +: 8];
    end
  endgenerate

  // Load lane extraction and extension
  always_comb begin
    load_shift = mem_rdata;
    load_ext   = mem_rdata;
    case (size_reg)
      SZ_BYTE: begin
        load_shift = mem_rdata >> {addr_reg[1:0], 3'b000};
        load_ext   = unsigned_reg ? {24'd0, load_shift[7:0]}
                                  : {{24{load_shift[7]}}, load_shift[7:0]};
      end
      SZ_HALF: begin
        load_shift = mem_rdata >> {addr_reg[1], 4'b0000};
        load_ext   = unsigned_reg ? {16'd0, load_shift[15:0]}
                                  : {{16{load_shift[15]}}, load_shift[15:0]};
      end
      default: begin
        load_shift = mem_rdata;
        load_ext   = mem_rdata;
      end
    endcase
  end

  // Request latch and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      wdata_reg     <= 32'd0;
      rdata_reg     <= 32'd0;
      mem_wdata_reg <= 32'd0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            we_reg       <= req_we;
            addr_reg     <= req_addr;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            wdata_reg    <= req_wdata;
            err_reg      <= req_err;
            rdata_reg    <= 32'd0;
            if (req_we && (req_size == SZ_WORD) && !req_err) begin
              mem_wdata_reg <= req_wdata;
            end
          end
        end
        READ: begin
          if (we_reg) begin
            mem_wdata_reg <= merged_word;
          end else begin
            rdata_reg <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_lsu.sv
// Scoreboard bench for mcu_lsu: stimulus queues expected responses, a forked monitor checks them.
module tb_mcu_lsu;

  localparam int MEM_WORDS = 256;
  localparam int ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [MEM_WORDS];
  logic        mem_clear = 1'b0;
  int          cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          we;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   we_cnt = 0;

  mcu_lsu #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory model: combinational read, write on the closing edge of mem_we.
  assign mem_rdata = (mem_address < ADDR_W'(MEM_WORDS)) ? mem[mem_address[7:0]] : 32'd0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
    end else if (mem_we && (mem_address < ADDR_W'(MEM_WORDS))) begin
      mem[mem_address[7:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_we) we_cnt++;
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h want no response", rsp_rdata);
          end else begin
            e = sb.pop_front();
            $display("txn %-16s rdata=%h err=%0d cyc=%0d we_cycles=%0d", e.name, rsp_rdata, rsp_err, cyc, we_cnt);
            chk({e.name, ".rdata"}, rsp_rdata, e.rdata);
            chk({e.name, ".err"}, 32'(rsp_err), 32'(e.err));
            chk({e.name, ".latency"}, 32'(cyc), 32'(e.cyc));
            chk({e.name, ".mem_we_cycles"}, 32'(we_cnt), 32'(e.we));
          end
          we_cnt = 0;
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.ready_timeout: got req_ready=0 want 1", name);
    end
  endtask

  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input int exp_we);
    exp_t e;
    @(negedge clk);
    wait_ready(name);
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + lat - 1;
    e.we    = exp_we;
    sb.push_back(e);
    chk({name, ".mem_address"}, mem_address, addr >> 2);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst_n     = 1'b0;
    mem_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.mem_address", mem_address, 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    mem_clear = 1'b0;
    rst_n     = 1'b1;

    // 1: word store then word load
    issue("st_w_0x10", 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 2, 1);
    issue("ld_w_0x10", 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 2, 0);
    drain();
    chk("mem4_after_st_w", mem[4], 32'hDEADBEEF);

    // 2: byte RMW into upper lane, signed/unsigned byte loads
    issue("st_w_0x10_b", 1, 32'h10, 2'b10, 0, 32'h11223344, 32'h0, 0, 2, 1);
    issue("st_b_0x13", 1, 32'h13, 2'b00, 0, 32'h000000A5, 32'h0, 0, 3, 1);
    drain();
    chk("mem4_after_st_b", mem[4], 32'hA5223344);
    issue("ld_b_s_0x13", 0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFFA5, 0, 2, 0);
    issue("ld_b_u_0x13", 0, 32'h13, 2'b00, 1, 32'h0, 32'h000000A5, 0, 2, 0);
    issue("ld_b_s_0x12", 0, 32'h12, 2'b00, 0, 32'h0, 32'h00000022, 0, 2, 0);

    // 3: half RMW into upper half of a zero word
    issue("st_h_0x16", 1, 32'h16, 2'b01, 0, 32'h00008001, 32'h0, 0, 3, 1);
    drain();
    chk("mem5_after_st_h", mem[5], 32'h80010000);
    issue("ld_h_s_0x16", 0, 32'h16, 2'b01, 0, 32'h0, 32'hFFFF8001, 0, 2, 0);
    issue("ld_h_u_0x16", 0, 32'h16, 2'b01, 1, 32'h0, 32'h00008001, 0, 2, 0);
    issue("ld_h_s_0x10", 0, 32'h10, 2'b01, 0, 32'h0, 32'h00003344, 0, 2, 0);

    // 4: misaligned word load
`ifdef LSU_ALIGN_CHECK_EN
    issue("ld_w_0x12_mis", 0, 32'h12, 2'b10, 0, 32'h0, 32'h0, 1, 1, 0);
`else
    issue("ld_w_0x12_trunc", 0, 32'h12, 2'b10, 0, 32'h0, 32'hA5223344, 0, 2, 0);
`endif
    drain();
    chk("mem4_after_mis", mem[4], 32'hA5223344);

    // 5: range, illegal size, high-bit aliasing, last word
    issue("st_w_0x400_oor", 1, 32'h400, 2'b10, 0, 32'h12345678, 32'h0, 1, 1, 0);
    issue("ld_sz11_0x10", 0, 32'h10, 2'b11, 0, 32'h0, 32'h0, 1, 1, 0);
    issue("st_sz11_0x14", 1, 32'h14, 2'b11, 0, 32'hFFFFFFFF, 32'h0, 1, 1, 0);
    issue("ld_w_alias", 0, 32'h80000010, 2'b10, 0, 32'h0, 32'h0, 1, 1, 0);
    issue("st_b_alias", 1, 32'h80000013, 2'b00, 0, 32'h000000EE, 32'h0, 1, 1, 0);
    issue("st_w_0x3fc", 1, 32'h3FC, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0, 2, 1);
    issue("ld_w_0x3fc", 0, 32'h3FC, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, 2, 0);
    issue("ld_b_u_0x3ff", 0, 32'h3FF, 2'b00, 1, 32'h0, 32'h000000CA, 0, 2, 0);
    drain();
    chk("mem4_after_errs", mem[4], 32'hA5223344);
    chk("mem5_after_errs", mem[5], 32'h80010000);
    chk("mem255_last_word", mem[255], 32'hCAFEF00D);

    // 6: reset during the WRITE cycle of a byte store
    issue("st_w_0x20", 1, 32'h20, 2'b10, 0, 32'h11223344, 32'h0, 0, 2, 1);
    drain();
    @(negedge clk);
    wait_ready("st_b_0x21_rst");
    req_we       = 1'b1;
    req_addr     = 32'h21;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_wdata    = 32'h00000077;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.write_phase_mem_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.mem_we_async", 32'(mem_we), 32'd0);
    chk("rst.req_ready_async", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst.mem8_kept", mem[8], 32'h11223344);
    chk("rst.req_ready_after", 32'(req_ready), 32'd1);
    issue("ld_w_0x20_post", 0, 32'h20, 2'b10, 0, 32'h0, 32'h11223344, 0, 2, 0);
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
